// File: rtl/fluxo_dados_jogadas.sv
// rtl/fluxo_dados_jogadas.sv - datapath for the button-sequence game: counters, play register, memory, edge detect
// Optional timeout logic is compiled in with FLUXO_TIMEOUT_EN.
module fluxo_dados_jogadas #(
    parameter int NUM_BOTOES     = 4,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  zeraR,
    input  logic                  registraR,
    input  logic                  zeraE,
    input  logic                  contaE,
    input  logic                  zeraL,
    input  logic                  contaL,
    input  logic                  gravaM,
    input  logic                  contaT,
    input  logic [NUM_BOTOES-1:0] botoes,
    output logic                  chavesIgualMemoria,
    output logic                  enderecoIgualLimite,
    output logic                  enderecoMenorLimite,
    output logic                  fimE,
    output logic                  fimL,
    output logic                  jogada_feita,
    output logic                  timeout,
    output logic                  db_tem_jogada,
    output logic [ADDR_W-1:0]     db_contagem,
    output logic [ADDR_W-1:0]     db_limite,
    output logic [NUM_BOTOES-1:0] db_jogada,
    output logic [NUM_BOTOES-1:0] db_memoria
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0]     endereco;
    logic [ADDR_W-1:0]     limite;
    logic [NUM_BOTOES-1:0] jogada;
    logic [NUM_BOTOES-1:0] dado_lido;
    logic                  tem_jogada_ant;
    logic [NUM_BOTOES-1:0] memoria [DEPTH];

    // Address and limit counters: clear has priority, natural wrap at the top.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco <= '0;
        end else if (zeraE) begin
            endereco <= '0;
        end else if (contaE) begin
            endereco <= endereco + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            limite <= '0;
        end else if (zeraL) begin
            limite <= '0;
        end else if (contaL) begin
            limite <= limite + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada <= '0;
        end else if (zeraR) begin
            jogada <= '0;
        end else if (registraR) begin
            jogada <= botoes;
        end
    end

    // Memory array has no reset so stored plays survive a reset.
    always_ff @(posedge clock) begin
        if (gravaM) begin
            memoria[endereco] <= jogada;
        end
    end

    // Read register samples the pre-write word, giving read-first behaviour.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dado_lido <= '0;
        end else begin
            dado_lido <= memoria[endereco];
        end
    end

    assign db_tem_jogada = |botoes;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tem_jogada_ant <= 1'b0;
            jogada_feita   <= 1'b0;
        end else begin
            tem_jogada_ant <= db_tem_jogada;
            jogada_feita   <= db_tem_jogada & ~tem_jogada_ant;
        end
    end

`ifdef FLUXO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] ULTIMA = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] conta_timeout;

    // Idle counter stops once timeout is set; any activity restarts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta_timeout <= '0;
            timeout       <= 1'b0;
        end else if (zeraE || contaE || jogada_feita) begin
            conta_timeout <= '0;
            timeout       <= 1'b0;
        end else if (contaT && !db_tem_jogada && !timeout) begin
            if (conta_timeout == ULTIMA) begin
                timeout <= 1'b1;
            end else begin
                conta_timeout <= conta_timeout + TW'(1);
            end
        end
    end
`else
    logic unused_contat;
    assign unused_contat = contaT & (TIMEOUT_CICLOS > 1);
    assign timeout       = 1'b0;
`endif

    assign fimE                = (endereco == {ADDR_W{1'b1}});
    assign fimL                = (limite == {ADDR_W{1'b1}});
    assign chavesIgualMemoria  = (jogada == dado_lido);
    assign enderecoIgualLimite = (endereco == limite);
    assign enderecoMenorLimite = (endereco < limite);

    assign db_contagem = endereco;
    assign db_limite   = limite;
    assign db_jogada   = jogada;
    assign db_memoria  = dado_lido;

endmodule

// File: tb/tb_fluxo_dados_jogadas.sv
// tb/tb_fluxo_dados_jogadas.sv - scoreboard bench for fluxo_dados_jogadas
module tb_fluxo_dados_jogadas;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       zeraR = 0, registraR = 0, zeraE = 0, contaE = 0;
    logic       zeraL = 0, contaL = 0, gravaM = 0, contaT = 0;
    logic [3:0] botoes = '0;
    logic       chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite;
    logic       fimE, fimL, jogada_feita, timeout, db_tem_jogada;
    logic [3:0] db_contagem, db_limite, db_jogada, db_memoria;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    localparam int S_CNT = 0, S_LIM = 1, S_JOG = 2, S_MEM = 3, S_JF = 4, S_TO = 5;
    localparam int S_FIME = 6, S_FIML = 7, S_IGM = 8, S_EQ = 9, S_LT = 10, S_TEM = 11;

    fluxo_dados_jogadas #(.NUM_BOTOES(4), .ADDR_W(4), .TIMEOUT_CICLOS(8)) dut (
        .clock(clock), .reset(reset),
        .zeraR(zeraR), .registraR(registraR), .zeraE(zeraE), .contaE(contaE),
        .zeraL(zeraL), .contaL(contaL), .gravaM(gravaM), .contaT(contaT),
        .botoes(botoes),
        .chavesIgualMemoria(chavesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
        .enderecoMenorLimite(enderecoMenorLimite), .fimE(fimE), .fimL(fimL),
        .jogada_feita(jogada_feita), .timeout(timeout), .db_tem_jogada(db_tem_jogada),
        .db_contagem(db_contagem), .db_limite(db_limite),
        .db_jogada(db_jogada), .db_memoria(db_memoria)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_CNT:   return 32'(db_contagem);
            S_LIM:   return 32'(db_limite);
            S_JOG:   return 32'(db_jogada);
            S_MEM:   return 32'(db_memoria);
            S_JF:    return 32'(jogada_feita);
            S_TO:    return 32'(timeout);
            S_FIME:  return 32'(fimE);
            S_FIML:  return 32'(fimL);
            S_IGM:   return 32'(chavesIgualMemoria);
            S_EQ:    return 32'(enderecoIgualLimite);
            S_LT:    return 32'(enderecoMenorLimite);
            default: return 32'(db_tem_jogada);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_strobes();
        {zeraR, registraR, zeraE, contaE, zeraL, contaL, gravaM} = '0;
    endtask

    int pulses;

    initial begin
        #1;
        expect_val("por_cnt", S_CNT, 0);
        expect_val("por_jf", S_JF, 0);
        expect_val("por_mem", S_MEM, 0);
        drain();
        tick();
        reset = 1'b1;
        tick();

        // Async reset mid-operation: address 5, limit 3, play register loaded.
        botoes = 4'b1010; registraR = 1; tick(); registraR = 0; botoes = 0;
        contaE = 1; tick(5); contaE = 0;
        contaL = 1; tick(3); contaL = 0;
        expect_val("pre_rst_cnt", S_CNT, 5);
        expect_val("pre_rst_lim", S_LIM, 3);
        expect_val("pre_rst_jog", S_JOG, 4'b1010);
        drain();
        contaE = 1; contaL = 1;
        #2 reset = 1'b0;
        #1;
        expect_val("rst_cnt", S_CNT, 0);
        expect_val("rst_lim", S_LIM, 0);
        expect_val("rst_jog", S_JOG, 0);
        expect_val("rst_jf", S_JF, 0);
        expect_val("rst_to", S_TO, 0);
        expect_val("rst_mem", S_MEM, 0);
        drain();
        clear_strobes();
        tick();
        reset = 1'b1;
        tick();
        expect_val("post_rst_cnt", S_CNT, 0);
        drain();

        // Address wrap and fimE, then clear-over-count priority.
        contaE = 1; tick(15);
        expect_val("cnt_15", S_CNT, 15);
        expect_val("fimE_15", S_FIME, 1);
        drain();
        tick();
        expect_val("cnt_wrap", S_CNT, 0);
        expect_val("fimE_wrap", S_FIME, 0);
        drain();
        tick(3);
        zeraE = 1; tick(); clear_strobes();
        expect_val("zera_wins", S_CNT, 0);
        drain();
        contaL = 1; tick(15); contaL = 0;
        expect_val("fimL_15", S_FIML, 1);
        drain();
        zeraL = 1; contaL = 1; tick(); clear_strobes();
        expect_val("zeraL_wins", S_LIM, 0);
        drain();

        // Memory write, read latency and read-first.
        botoes = 4'b0100; registraR = 1; tick(); registraR = 0; botoes = 0;
        contaE = 1; tick(2); contaE = 0;
        gravaM = 1; tick(); gravaM = 0;
        zeraE = 1; tick(); zeraE = 0;
        contaE = 1; tick(2); contaE = 0;
        tick();
        expect_val("mem_rd2", S_MEM, 4'b0100);
        expect_val("igual_mem", S_IGM, 1);
        drain();
        botoes = 4'b0001; registraR = 1; tick(); registraR = 0; botoes = 0;
        expect_val("diff_mem", S_IGM, 0);
        drain();
        gravaM = 1; tick(); gravaM = 0;
        expect_val("read_first_old", S_MEM, 4'b0100);
        drain();
        tick();
        expect_val("read_first_new", S_MEM, 4'b0001);
        expect_val("igual_mem2", S_IGM, 1);
        drain();
        reset = 1'b0; #1 reset = 1'b1;
        tick();
        contaE = 1; tick(2); contaE = 0;
        tick();
        expect_val("mem_keeps", S_MEM, 4'b0001);
        drain();

        // Address versus limit comparisons.
        zeraL = 1; tick(); zeraL = 0;
        contaL = 1; tick(3); contaL = 0;
        zeraE = 1; tick(); zeraE = 0;
        contaE = 1; tick(2); contaE = 0;
        expect_val("lt_at2", S_LT, 1);
        expect_val("eq_at2", S_EQ, 0);
        drain();
        contaE = 1; tick(); contaE = 0;
        expect_val("eq_at3", S_EQ, 1);
        expect_val("lt_at3", S_LT, 0);
        drain();
        contaE = 1; tick(); contaE = 0;
        expect_val("lt_at4", S_LT, 0);
        drain();

        // Edge detector: one pulse per press, re-armed after a release.
        tick(2);
        botoes = 4'b0001;
        #1;
        expect_val("tem_jogada", S_TEM, 1);
        expect_val("jf_same_cycle", S_JF, 0);
        drain();
        tick();
        expect_val("jf_pulse", S_JF, 1);
        drain();
        pulses = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (jogada_feita) pulses++;
        end
        check("held_one_pulse", 32'(pulses), 1);
        botoes = 0; tick();
        expect_val("tem_released", S_TEM, 0);
        drain();
        botoes = 4'b1000; tick();
        expect_val("jf_second", S_JF, 1);
        drain();
        tick();
        expect_val("jf_second_end", S_JF, 0);
        drain();
        botoes = 0; tick(2);

`ifdef FLUXO_TIMEOUT_EN
        contaT = 1; zeraE = 1; tick(); zeraE = 0;
        tick(7);
        expect_val("to_before", S_TO, 0);
        drain();
        tick();
        expect_val("to_rise", S_TO, 1);
        drain();
        tick(4);
        expect_val("to_sticky", S_TO, 1);
        drain();
        contaE = 1; tick(); contaE = 0;
        expect_val("to_cleared", S_TO, 0);
        drain();
        contaT = 0;
`else
        contaT = 1; tick(20); contaT = 0;
        expect_val("to_disabled", S_TO, 0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
